// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, bit-timing widths and the parity helper.
// Also intended for the receive-side deserializer.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT_START,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   localparam int OVS_DEFAULT = 16;
   localparam int TICK_W      = 4;
   localparam int BIT_CNT_W   = 3;

   // Parity over the active data bits; bit 7 does not count in 7-bit frames.
   function automatic logic frame_parity(input logic [7:0] data,
                                         input logic       bit8,
                                         input logic       odd);
      logic [7:0] d;
      d = bit8 ? data : {1'b0, data[6:0]};
      return (^d) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from the TX FIFO and shifts each out as
// start / 7-8 data bits LSB-first / optional parity / stop, timed by a 16x baud enable.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int RD_LAT = 2,
   parameter int OVS    = OVS_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       baud_en,
   input  logic       bit8,
   input  logic       parity_en,
   input  logic       odd_n_even,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       tx_rdb,
   output logic       tx,
   output logic       tx_busy,
   output logic       frame_done
);

   localparam int                 LAT_W     = $clog2(RD_LAT + 1);
   localparam logic [LAT_W-1:0]   LAT_LAST  = LAT_W'(RD_LAT);
   localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(OVS - 1);

   tx_state_e              state_reg, state_next;
   logic [TICK_W-1:0]      tick_reg, tick_next;
   logic [BIT_CNT_W-1:0]   bit_reg, bit_next;
   logic [LAT_W-1:0]       lat_reg, lat_next;
   logic [7:0]             shift_reg, shift_next;
   logic                   par_reg, par_next;
   logic                   bit8_reg, bit8_next;
   logic                   paren_reg, paren_next;
   logic                   tx_reg, tx_next;
   logic                   rdb_reg, rdb_next;
   logic                   done_reg, done_next;

   logic                   bit_end;
   logic [BIT_CNT_W-1:0]   last_bit;

   assign bit_end  = baud_en && (tick_reg == TICK_LAST);
   assign last_bit = bit8_reg ? BIT_CNT_W'(7) : BIT_CNT_W'(6);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         tick_reg  <= '0;
         bit_reg   <= '0;
         lat_reg   <= '0;
         shift_reg <= '0;
         par_reg   <= 1'b0;
         bit8_reg  <= 1'b0;
         paren_reg <= 1'b0;
         tx_reg    <= 1'b1;
         rdb_reg   <= 1'b1;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         tick_reg  <= tick_next;
         bit_reg   <= bit_next;
         lat_reg   <= lat_next;
         shift_reg <= shift_next;
         par_reg   <= par_next;
         bit8_reg  <= bit8_next;
         paren_reg <= paren_next;
         tx_reg    <= tx_next;
         rdb_reg   <= rdb_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      tick_next  = tick_reg;
      bit_next   = bit_reg;
      lat_next   = lat_reg;
      shift_next = shift_reg;
      par_next   = par_reg;
      bit8_next  = bit8_reg;
      paren_next = paren_reg;
      tx_next    = tx_reg;
      rdb_next   = 1'b1;
      done_next  = 1'b0;

      // Tick counter only runs while a bit is on the line.
      if (baud_en && (state_reg inside {START, DATA, PARITY, STOP}))
         tick_next = (tick_reg == TICK_LAST) ? '0 : tick_reg + 1'b1;

      case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               rdb_next   = 1'b0;
               lat_next   = '0;
               state_next = FETCH;
            end
         end
         FETCH: begin
            // Configuration is frozen here so mid-frame register writes only affect the next byte.
            if (lat_reg == LAT_LAST) begin
               shift_next = fifo_data;
               bit8_next  = bit8;
               paren_next = parity_en;
               par_next   = frame_parity(fifo_data, bit8, odd_n_even);
               state_next = WAIT_START;
            end else begin
               lat_next = lat_reg + 1'b1;
            end
         end
         WAIT_START: begin
            if (baud_en) begin
               tx_next    = 1'b0;
               tick_next  = '0;
               state_next = START;
            end
         end
         START: begin
            if (bit_end) begin
               tx_next    = shift_reg[0];
               shift_next = shift_reg >> 1;
               bit_next   = '0;
               state_next = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_reg == last_bit) begin
                  tx_next    = paren_reg ? par_reg : 1'b1;
                  state_next = paren_reg ? PARITY : STOP;
               end else begin
                  tx_next    = shift_reg[0];
                  shift_next = shift_reg >> 1;
                  bit_next   = bit_reg + 1'b1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               tx_next    = 1'b1;
               state_next = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               done_next = 1'b1;
               if (!fifo_empty) begin
                  rdb_next   = 1'b0;
                  lat_next   = '0;
                  state_next = FETCH;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign tx_rdb     = rdb_reg;
   assign tx         = tx_reg;
   assign tx_busy    = (state_reg != IDLE);
   assign frame_done = done_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: FIFO model with read latency, frame reference model
// built at capture time, and a line monitor that checks every bit cycle-by-cycle.
module tb_uart_tx_serializer;

   localparam int OVS      = 16;
   localparam int RD_LAT   = 2;
   localparam int BAUD_DIV = 4;
   localparam int P        = OVS * BAUD_DIV;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       baud_en = 1'b0;
   logic       bit8 = 1'b1;
   logic       parity_en = 1'b0;
   logic       odd_n_even = 1'b0;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_data = 8'h00;
   logic       tx_rdb, tx, tx_busy, frame_done;

   int errors = 0;
   int checks = 0;

   uart_tx_serializer #(.RD_LAT(RD_LAT), .OVS(OVS)) dut (
      .clk        (clk),
      .reset      (reset),
      .baud_en    (baud_en),
      .bit8       (bit8),
      .parity_en  (parity_en),
      .odd_n_even (odd_n_even),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .tx_rdb     (tx_rdb),
      .tx         (tx),
      .tx_busy    (tx_busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input bit ok, input string name, input int act, input int req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Baud enable: one cycle in every BAUD_DIV.
   int bcnt = 0;
   always @(negedge clk) begin
      bcnt    = (bcnt + 1) % BAUD_DIV;
      baud_en = (bcnt == 0);
   end

   // Reference model: expected frame from the configuration present at capture.
   logic [11:0] exp_f_q[$];
   int          exp_n_q[$];

   function automatic void push_expected(input logic [7:0] d);
      logic [11:0] f;
      int nd, ones, n;
      f    = '0;
      nd   = bit8 ? 8 : 7;
      ones = 0;
      for (int i = 0; i < nd; i++) begin
         f[1+i] = d[i];
         ones  += int'(d[i]);
      end
      n = 1 + nd;
      if (parity_en) begin
         f[n] = odd_n_even ? (ones % 2 == 0) : (ones % 2 == 1);
         n++;
      end
      f[n] = 1'b1;
      n++;
      exp_f_q.push_back(f);
      exp_n_q.push_back(n);
   endfunction

   // TX FIFO model: data becomes valid RD_LAT cycles after the strobe cycle.
   logic [7:0] fifo_q[$];
   logic [7:0] pend;
   int         lat = 0;
   int         strobes = 0;
   bit         prev_low = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         lat      = 0;
         prev_low = 1'b0;
      end else begin
         if (lat == RD_LAT) begin
            fifo_data = pend;
            push_expected(pend);
            lat = 0;
         end else if (lat > 0) begin
            lat++;
         end
         if (!tx_rdb) begin
            strobes++;
            check(!prev_low, "strobe_width", 2, 1);
            check(fifo_q.size() > 0, "strobe_when_empty", 0, 1);
            if (fifo_q.size() > 0) begin
               pend      = fifo_q.pop_front();
               fifo_data = 8'($urandom);
               lat       = 1;
            end
         end
         prev_low = !tx_rdb;
      end
      fifo_empty = (fifo_q.size() == 0);
   end

   // Line monitor.
   bit          mon_active = 1'b0;
   int          mon_idx = 0;
   int          mon_n = 0;
   logic [11:0] mon_f;
   bit          bit_bad = 1'b0;
   int          frames_seen = 0;
   int          frames_started = 0;
   int          cyc = 0;
   int          last_end = -100000;
   int          gaps[$];

   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         mon_active = 1'b0;
      end else begin
         if (!mon_active && tx == 1'b0) begin
            if (exp_n_q.size() == 0) begin
               check(1'b0, "unexpected_start", 0, 1);
            end else begin
               mon_f      = exp_f_q.pop_front();
               mon_n      = exp_n_q.pop_front();
               mon_active = 1'b1;
               mon_idx    = 0;
               bit_bad    = 1'b0;
               gaps.push_back(cyc - last_end);
               frames_started++;
            end
         end
         if (mon_active) begin
            if (mon_idx < mon_n * P) begin
               if (tx !== mon_f[mon_idx / P] || frame_done !== 1'b0 || tx_busy !== 1'b1)
                  bit_bad = 1'b1;
               if (mon_idx % P == P - 1) begin
                  check(!bit_bad, $sformatf("frame%0d_bit%0d", frames_started, mon_idx / P),
                        int'(tx), int'(mon_f[mon_idx / P]));
                  bit_bad = 1'b0;
               end
            end else begin
               check(frame_done === 1'b1, "frame_done", int'(frame_done), 1);
               mon_active = 1'b0;
               frames_seen++;
               last_end = cyc;
            end
            mon_idx++;
         end else if (frame_done !== 1'b0) begin
            check(1'b0, "stray_frame_done", int'(frame_done), 0);
         end
      end
   end

   task automatic push(input logic [7:0] d);
      fifo_q.push_back(d);
   endtask

   task automatic wait_frames(input int target);
      int budget;
      budget = (target - frames_seen + 1) * 14 * P + 2000;
      while (frames_seen < target && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (frames_seen < target) check(1'b0, "frame_timeout", frames_seen, target);
   endtask

   task automatic wait_idle();
      int budget;
      budget = 4000;
      do begin
         @(negedge clk);
         #1;
         budget--;
      end while ((tx_busy !== 1'b0 || fifo_q.size() != 0) && budget > 0);
      check(tx_busy === 1'b0, "idle_busy", int'(tx_busy), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, f0, budget, target;
      bit bad;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      #1;
      check(tx === 1'b1, "reset_tx", int'(tx), 1);
      check(tx_rdb === 1'b1, "reset_rdb", int'(tx_rdb), 1);
      check(tx_busy === 1'b0, "reset_busy", int'(tx_busy), 0);
      check(frame_done === 1'b0, "reset_done", int'(frame_done), 0);

      // Empty FIFO: line and strobe stay idle.
      bad = 1'b0;
      repeat (1000) begin
         @(negedge clk);
         if (tx !== 1'b1 || tx_rdb !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
      end
      check(!bad, "idle_empty", int'(bad), 0);

      // 0x55, 8 bits, no parity.
      @(posedge clk); #1;
      bit8 = 1'b1; parity_en = 1'b0;
      s0 = strobes; f0 = frames_seen;
      push(8'h55);
      wait_frames(f0 + 1);
      wait_idle();
      check(strobes - s0 == 1, "strobes_55", strobes - s0, 1);

      // 0x83, 7 bits, odd parity.
      @(posedge clk); #1;
      bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b1;
      f0 = frames_seen;
      push(8'h83);
      wait_frames(f0 + 1);
      wait_idle();

      // Three queued bytes go out back-to-back.
      @(posedge clk); #1;
      bit8 = 1'b1; parity_en = 1'b0;
      s0 = strobes; f0 = frames_seen;
      gaps.delete();
      push(8'hA5); push(8'h00); push(8'hFF);
      wait_frames(f0 + 3);
      wait_idle();
      check(strobes - s0 == 3, "strobes_b2b", strobes - s0, 3);
      check(gaps.size() == 3, "b2b_frames", gaps.size(), 3);
      if (gaps.size() == 3) begin
         check(gaps[1] <= 2 * BAUD_DIV + RD_LAT + 1, "b2b_gap1", gaps[1], 2 * BAUD_DIV + RD_LAT + 1);
         check(gaps[2] <= 2 * BAUD_DIV + RD_LAT + 1, "b2b_gap2", gaps[2], 2 * BAUD_DIV + RD_LAT + 1);
      end

      // Reset in the middle of data bit 3 (that bit is 0 for 0x37).
      @(posedge clk); #1;
      f0 = frames_started;
      push(8'h37);
      budget = 20 * P;
      do begin
         @(negedge clk);
         #1;
         budget--;
      end while (!(frames_started > f0 && mon_active && mon_idx >= 4 * P + P / 2) && budget > 0);
      check(budget > 0, "reset_wait", budget, 1);
      reset = 1'b1;
      @(negedge clk);
      #1;
      check(tx === 1'b1, "abort_tx", int'(tx), 1);
      check(tx_busy === 1'b0, "abort_busy", int'(tx_busy), 0);
      check(tx_rdb === 1'b1, "abort_rdb", int'(tx_rdb), 1);
      reset = 1'b0;
      @(posedge clk); #1;
      f0 = frames_seen;
      push(8'h96);
      wait_frames(f0 + 1);
      wait_idle();

      // Parity enabled during frame 1: only frame 2 carries a parity bit.
      @(posedge clk); #1;
      bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
      f0 = frames_seen; s0 = frames_started;
      push(8'h5A); push(8'hC3);
      budget = 20 * P;
      while (frames_started == s0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      repeat (3 * P) @(posedge clk);
      #1 parity_en = 1'b1;
      wait_frames(f0 + 2);
      wait_idle();

      // Randomized traffic and configuration changes.
      target = frames_seen;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         bit8       = 1'($urandom);
         parity_en  = 1'($urandom);
         odd_n_even = 1'($urandom);
         if ($urandom_range(0, 2) != 0) begin
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
               push(8'($urandom));
               target++;
            end
         end
         repeat ($urandom_range(0, 600)) @(posedge clk);
      end
      wait_frames(target);
      wait_idle();
      check(exp_n_q.size() == 0, "exp_drained", exp_n_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
